seq_alu: RTL and testbench

Parametrised, registered successor to the datapath combinational ALU. It keeps the existing single-cycle opcodes and adds iterative multiply/divide and shift operations behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle core. The controller issues one operation and waits for done.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/mul_div_unit.sv | 72 +++++++
 rtl/seq_alu.sv | 135 +++++++++++++
 tb/tb_seq_alu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, controller states and the classifier that picks
// between the single-cycle path and the iterative mul/div engine.
package alu_pkg;

  localparam logic [3:0] OPC_AND   = 4'b0000;
  localparam logic [3:0] OPC_OR    = 4'b0001;
  localparam logic [3:0] OPC_ADD   = 4'b0010;
  localparam logic [3:0] OPC_XOR   = 4'b0011;
  localparam logic [3:0] OPC_SLL   = 4'b0100;
  localparam logic [3:0] OPC_SRL   = 4'b0101;
  localparam logic [3:0] OPC_SUB   = 4'b0110;
  localparam logic [3:0] OPC_SLT   = 4'b0111;
  localparam logic [3:0] OPC_SLTU  = 4'b1000;
  localparam logic [3:0] OPC_MUL   = 4'b1001;
  localparam logic [3:0] OPC_MULHU = 4'b1010;
  localparam logic [3:0] OPC_DIVU  = 4'b1011;
  localparam logic [3:0] OPC_REMU  = 4'b1100;
  localparam logic [3:0] OPC_SRA   = 4'b1101;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic is_iterative(input logic [3:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_MULHU) ||
           (opc == OPC_DIVU) || (opc == OPC_REMU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 shift-add multiplier / restoring divider sharing one hi:lo register.
// The load cycle already performs the first iteration, so WIDTH-1 further steps finish the op.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
  logic             div_reg;
  logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
  logic             cur_div;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH:0]   shifted, trial, sum;

  assign cur_hi  = load ? '0 : hi_reg;
  assign cur_lo  = load ? a : lo_reg;
  assign cur_b   = load ? b : b_reg;
  assign cur_div = load ? is_div : div_reg;

  // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  // Multiply: lo holds the multiplier, product bits enter lo from the top.
  always_comb begin
    shifted = {cur_hi, cur_lo[WIDTH-1]};
    trial   = shifted - {1'b0, cur_b};
    sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
    hi_next = '0;
    lo_next = '0;
    if (cur_div) begin
      if (shifted >= {1'b0, cur_b}) begin
        hi_next = trial[WIDTH-1:0];
        lo_next = {cur_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {cur_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      b_reg   <= '0;
      div_reg <= 1'b0;
    end else begin
      if (load) begin
        b_reg   <= b;
        div_reg <= is_div;
      end
      if (load || step) begin
        hi_reg <= hi_next;
        lo_reg <= lo_next;
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle ops finish in one cycle,
// MUL/MULHU/DIVU/REMU run WIDTH cycles through mul_div_unit behind start/busy/done.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             div_zero,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             op_hi_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg, neg_reg, div_zero_reg, illegal_reg;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] fast_res;
  logic             fast_dz, fast_ill;
  logic             b_zero, is_div_op, iter_go, accept;
  logic [WIDTH-1:0] eng_hi, eng_lo, iter_res;

  assign shamt     = src_b[SH_W-1:0];
  assign b_zero    = (src_b == '0);
  assign is_div_op = (opc == OPC_DIVU) || (opc == OPC_REMU);
  // Divide by zero short-circuits to the single-cycle path.
  assign iter_go   = is_iterative(opc) && !(is_div_op && b_zero);
  assign accept    = start && (state_reg != RUN);

  always_comb begin
    fast_res = '0;
    fast_dz  = 1'b0;
    fast_ill = 1'b0;
    case (opc)
      OPC_AND:  fast_res = src_a & src_b;
      OPC_OR:   fast_res = src_a | src_b;
      OPC_ADD:  fast_res = src_a + src_b;
      OPC_XOR:  fast_res = src_a ^ src_b;
      OPC_SLL:  fast_res = src_a << shamt;
      OPC_SRL:  fast_res = src_a >> shamt;
      OPC_SUB:  fast_res = src_a - src_b;
      OPC_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OPC_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OPC_SRA:  fast_res = $unsigned($signed(src_a) >>> shamt);
      OPC_DIVU: begin fast_res = '1;    fast_dz = 1'b1; end
      OPC_REMU: begin fast_res = src_a; fast_dz = 1'b1; end
      OPC_MUL, OPC_MULHU: fast_res = '0;
      default:  fast_ill = 1'b1;
    endcase
  end

  mul_div_unit #(.WIDTH(WIDTH)) u_mul_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && iter_go),
    .is_div (is_div_op),
    .a      (src_a),
    .b      (src_b),
    .step   ((state_reg == RUN) && (cnt_reg != LAST)),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );

  // MULHU wants the product high half, REMU the remainder: both live in hi.
  assign iter_res = op_hi_reg ? eng_hi : eng_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_hi_reg    <= 1'b0;
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      neg_reg      <= 1'b0;
      div_zero_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (cnt_reg == LAST) begin
            state_reg    <= DONE;
            result_reg   <= iter_res;
            zero_reg     <= (iter_res == '0);
            neg_reg      <= iter_res[WIDTH-1];
            div_zero_reg <= 1'b0;
            illegal_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (!start) begin
            state_reg <= IDLE;
          end else if (iter_go) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            op_hi_reg <= (opc == OPC_MULHU) || (opc == OPC_REMU);
          end else begin
            state_reg    <= DONE;
            result_reg   <= fast_res;
            zero_reg     <= (fast_res == '0);
            neg_reg      <= fast_res[WIDTH-1];
            div_zero_reg <= fast_dz;
            illegal_reg  <= fast_ill;
          end
        end
      endcase
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign result   = result_reg;
  assign zero     = zero_reg;
  assign neg      = neg_reg;
  assign div_zero = div_zero_reg;
  assign illegal  = illegal_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): vector table plus hand-written reset and back-to-back
// sequences; expected results go into a queue and are checked whenever done pulses.
module tb_seq_alu;

  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3;
  localparam logic [3:0] C_SLL = 4'h4, C_SRL = 4'h5, C_SUB = 4'h6, C_SLT = 4'h7;
  localparam logic [3:0] C_SLTU = 4'h8, C_MUL = 4'h9, C_MULHU = 4'hA, C_DIVU = 4'hB;
  localparam logic [3:0] C_REMU = 4'hC, C_SRA = 4'hD;

  typedef struct {
    logic [31:0] r;
    logic        dz;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        dz;
    logic        ill;
    int          lat;
  } vec_t;

  logic        clk, rst_n, start;
  logic [3:0]  opc;
  logic [31:0] src_a, src_b;
  logic        busy, done, zero, neg, div_zero, illegal;
  logic [31:0] result;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t tbl[22];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opc(opc), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result), .zero(zero), .neg(neg),
    .div_zero(div_zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("zero", {31'd0, zero}, {31'd0, e.r == 32'd0});
        chk("neg", {31'd0, neg}, {31'd0, e.r[31]});
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        $display("done: result=%h zero=%b neg=%b dz=%b ill=%b", result, zero, neg, div_zero, illegal);
      end
    end
  end

  task automatic issue(input vec_t v);
    int lat, busy_cnt;
    exp_t e;
    @(negedge clk);
    start = 1'b1; opc = v.opc; src_a = v.a; src_b = v.b;
    e.r = v.r; e.dz = v.dz; e.ill = v.ill;
    sb.push_back(e);
    @(negedge clk);
    // Scramble the operand bus after accept; the DUT must have captured them.
    start = 1'b0; opc = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    $display("op opc=%h a=%h b=%h latency=%0d busy_cycles=%0d", v.opc, v.a, v.b, lat, busy_cnt);
    chk("latency", lat, v.lat);
    chk("busy_cycles", busy_cnt, (v.lat == 33) ? 32 : 0);
  endtask

  initial begin
    int lat;
    vec_t v;
    tbl[0]  = '{C_MUL,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 33};
    tbl[1]  = '{C_MULHU, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 1'b0, 1'b0, 33};
    tbl[2]  = '{C_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33};
    tbl[3]  = '{C_REMU,  32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33};
    tbl[4]  = '{C_DIVU,  32'h12345678, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 1};
    tbl[5]  = '{C_REMU,  32'h12345678, 32'h0,        32'h12345678, 1'b1, 1'b0, 1};
    tbl[6]  = '{C_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1};
    tbl[7]  = '{C_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1};
    tbl[8]  = '{C_SRA,   32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'hF,    32'h11111111, 32'h2,        32'h0,        1'b0, 1'b1, 1};
    tbl[10] = '{4'hE,    32'h5,        32'h5,        32'h0,        1'b0, 1'b1, 1};
    tbl[11] = '{C_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
    tbl[12] = '{C_OR,    32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
    tbl[13] = '{C_XOR,   32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1};
    tbl[14] = '{C_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1};
    tbl[15] = '{C_SUB,   32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1};
    tbl[16] = '{C_SLL,   32'h1,        32'h25,       32'h20,       1'b0, 1'b0, 1};
    tbl[17] = '{C_SRL,   32'h80000000, 32'h3F,       32'h1,        1'b0, 1'b0, 1};
    tbl[18] = '{C_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 33};
    tbl[19] = '{C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
    tbl[20] = '{C_REMU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 1'b0, 1'b0, 33};
    tbl[21] = '{C_DIVU,  32'd5,        32'd7,        32'd0,        1'b0, 1'b0, 33};

    rst_n = 1'b0; start = 1'b0; opc = 4'h0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_flags", {29'd0, neg, div_zero, illegal}, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a multiply: abandoned, no done.
    @(negedge clk);
    start = 1'b1; opc = C_MUL; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midmul_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midmul_busy", {31'd0, busy}, 32'd0);
    chk("midmul_done", {31'd0, done}, 32'd0);
    chk("midmul_result", result, 32'd0);
    chk("midmul_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midmul_idle_busy", {31'd0, busy}, 32'd0);
    v = '{C_ADD, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
    issue(v);

    for (int i = 0; i < 22; i++) issue(tbl[i]);

    // start held across a whole DIVU, then a back-to-back ADD accepted in the DONE cycle.
    @(negedge clk);
    start = 1'b1; opc = C_DIVU; src_a = 32'd100; src_b = 32'd7;
    sb.push_back('{32'd14, 1'b0, 1'b0});
    @(negedge clk);
    opc = C_ADD; src_a = 32'd3; src_b = 32'd4;
    sb.push_back('{32'd7, 1'b0, 1'b0});
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    $display("held-start DIVU latency=%0d", lat);
    chk("held_div_latency", lat, 33);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("b2b_done_clear", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
